// File: rtl/coin_acceptor.sv
// Coin acceptor: payment front-end for the washing-machine control unit.
// Accumulates credit, launches single/double wash, returns change and refunds
// on cancel or inactivity. Every output is registered.
module coin_acceptor #(
  parameter int CREDIT_W       = 8,
  parameter int SINGLE_PRICE   = 100,
  parameter int DOUBLE_PRICE   = 150,
  parameter int MAX_CREDIT     = 250,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                double_req,
  input  logic                start,
  input  logic                cancel,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RUN     = 3'd3,
    ST_REFUND  = 3'd4
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_1   = CREDIT_W'(SINGLE_PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_2   = CREDIT_W'(DOUBLE_PRICE);
  localparam logic [TO_W-1:0]     IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_W:0]   VAL_25    = (CREDIT_W+1)'(25);
  localparam logic [CREDIT_W:0]   VAL_50    = (CREDIT_W+1)'(50);
  localparam logic [CREDIT_W:0]   VAL_100   = (CREDIT_W+1)'(100);

  // Coin face value, zero for the invalid code (which is always rejected).
  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] ct);
    case (ct)
      2'd0:    return VAL_25;
      2'd1:    return VAL_50;
      2'd2:    return VAL_100;
      default: return '0;
    endcase
  endfunction

  state_t                state_r, next_state_s;
  logic [CREDIT_W-1:0]   credit_r, credit_d;
  logic [CREDIT_W-1:0]   change_amount_r, change_amount_d;
  logic [TO_W-1:0]       idle_cnt_r, idle_cnt_d;
  logic                  coin_in_r, coin_in_d;
  logic                  double_wash_r, double_wash_d;
  logic                  coin_reject_r, coin_reject_d;
  logic                  change_valid_r, change_valid_d;
  logic                  busy_r, busy_d;

  logic                  coin_ok_s;
  logic [CREDIT_W:0]     sum_s;
  logic                  fits_s;
  logic [CREDIT_W-1:0]   price_s;
  logic                  can_start_s;
  logic                  timeout_s;

  // Shared datapath terms; the sum is one bit wider so it can never wrap.
  assign coin_ok_s   = coin_valid && (coin_type != 2'd3);
  assign sum_s       = {1'b0, credit_r} + coin_value(coin_type);
  assign fits_s      = (sum_s <= MAX_SUM);
  assign price_s     = double_req ? PRICE_2 : PRICE_1;
  assign can_start_s = start && (credit_r >= price_s);
  assign timeout_s   = (idle_cnt_r == IDLE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; in COLLECT the priority is cancel > coin > start > timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) next_state_s = ST_COLLECT;
        else           next_state_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (cancel)           next_state_s = ST_REFUND;
        else if (coin_valid)  next_state_s = ST_COLLECT;
        else if (can_start_s) next_state_s = ST_LAUNCH;
        else if (timeout_s)   next_state_s = ST_REFUND;
        else                  next_state_s = ST_COLLECT;
      end
      ST_LAUNCH: next_state_s = ST_RUN;
      ST_RUN: begin
        if (wash_done) next_state_s = ST_IDLE;
        else           next_state_s = ST_RUN;
      end
      ST_REFUND: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, so each response
  // appears in the cycle right after the strobe that caused it.
  always_comb begin
    credit_d        = credit_r;
    change_amount_d = '0;
    idle_cnt_d      = '0;
    coin_in_d       = 1'b0;
    double_wash_d   = double_wash_r;
    coin_reject_d   = 1'b0;
    change_valid_d  = 1'b0;
    busy_d          = (next_state_s == ST_LAUNCH) || (next_state_s == ST_RUN);
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) credit_d = sum_s[CREDIT_W-1:0];
        else           coin_reject_d = coin_valid;
      end
      ST_COLLECT: begin
        if (cancel) begin
          // A coin in the cancel cycle is handed back, credit is refunded.
          coin_reject_d   = coin_valid;
          change_valid_d  = 1'b1;
          change_amount_d = credit_r;
        end else if (coin_valid) begin
          if (coin_ok_s && fits_s) credit_d = sum_s[CREDIT_W-1:0];
          else                     coin_reject_d = 1'b1;
        end else if (can_start_s) begin
          coin_in_d     = 1'b1;
          double_wash_d = double_req;
          if (credit_r > price_s) begin
            change_valid_d  = 1'b1;
            change_amount_d = credit_r - price_s;
          end else begin
            change_valid_d  = 1'b0;
          end
        end else if (timeout_s) begin
          change_valid_d  = 1'b1;
          change_amount_d = credit_r;
        end else begin
          idle_cnt_d = idle_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_LAUNCH: begin
        credit_d      = '0;
        coin_reject_d = coin_valid;
      end
      ST_RUN: begin
        coin_reject_d = coin_valid;
        if (wash_done) double_wash_d = 1'b0;
        else           double_wash_d = double_wash_r;
      end
      ST_REFUND: begin
        credit_d      = '0;
        coin_reject_d = coin_valid;
      end
      default: begin
        credit_d      = '0;
        double_wash_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset forfeits credit without a refund.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r        <= '0;
      change_amount_r <= '0;
      idle_cnt_r      <= '0;
      coin_in_r       <= 1'b0;
      double_wash_r   <= 1'b0;
      coin_reject_r   <= 1'b0;
      change_valid_r  <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      credit_r        <= credit_d;
      change_amount_r <= change_amount_d;
      idle_cnt_r      <= idle_cnt_d;
      coin_in_r       <= coin_in_d;
      double_wash_r   <= double_wash_d;
      coin_reject_r   <= coin_reject_d;
      change_valid_r  <= change_valid_d;
      busy_r          <= busy_d;
    end
  end

  assign coin_in       = coin_in_r;
  assign double_wash   = double_wash_r;
  assign coin_reject   = coin_reject_r;
  assign change_valid  = change_valid_r;
  assign change_amount = change_amount_r;
  assign credit        = credit_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: table-driven vectors with a
// scoreboard queue, plus hand-written timeout and corner sequences.
module tb_coin_acceptor;

  localparam int TIMEOUT = 1000;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       double_req;
  logic       start;
  logic       cancel;
  logic       wash_done;
  logic       coin_in;
  logic       double_wash;
  logic       coin_reject;
  logic       change_valid;
  logic [7:0] change_amount;
  logic [7:0] credit;
  logic       busy;

  coin_acceptor dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .double_req(double_req), .start(start), .cancel(cancel),
    .wash_done(wash_done), .coin_in(coin_in), .double_wash(double_wash),
    .coin_reject(coin_reject), .change_valid(change_valid),
    .change_amount(change_amount), .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       double_req;
    logic       start;
    logic       cancel;
    logic       wash_done;
  } in_t;

  typedef struct packed {
    logic       coin_in;
    logic       double_wash;
    logic       coin_reject;
    logic       change_valid;
    logic [7:0] change_amount;
    logic [7:0] credit;
    logic       busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic in_t inp(bit rs, bit cv, logic [1:0] ct, bit dr, bit st, bit ca, bit wd);
    in_t r;
    r.rst = rs; r.coin_valid = cv; r.coin_type = ct; r.double_req = dr;
    r.start = st; r.cancel = ca; r.wash_done = wd;
    return r;
  endfunction

  function automatic out_t outp(bit ci, bit dw, bit cr, bit chv, logic [7:0] cha, logic [7:0] cred, bit bz);
    out_t r;
    r.coin_in = ci; r.double_wash = dw; r.coin_reject = cr; r.change_valid = chv;
    r.change_amount = cha; r.credit = cred; r.busy = bz;
    return r;
  endfunction

  function automatic vec_t mk(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    return v;
  endfunction

  // Input shorthands
  function automatic in_t nop();                return inp(0, 0, 2'd0, 0, 0, 0, 0); endfunction
  function automatic in_t coin(logic [1:0] ct); return inp(0, 1, ct, 0, 0, 0, 0);   endfunction

  // Drive one cycle, push expectation, then pop and compare after the edge.
  task automatic apply(input in_t i, input out_t e, input string name, input int idx);
    out_t act;
    out_t exp_o;
    rst = i.rst; coin_valid = i.coin_valid; coin_type = i.coin_type;
    double_req = i.double_req; start = i.start; cancel = i.cancel;
    wash_done = i.wash_done;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    act = '{coin_in, double_wash, coin_reject, change_valid, change_amount, credit, busy};
    exp_o = exp_q.pop_front();
    total_cnt++;
    if (act === exp_o) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s[%0d]: got ci=%b dw=%b rej=%b chv=%b cha=%0d cred=%0d busy=%b, expected ci=%b dw=%b rej=%b chv=%b cha=%0d cred=%0d busy=%b",
               name, idx, act.coin_in, act.double_wash, act.coin_reject, act.change_valid,
               act.change_amount, act.credit, act.busy, exp_o.coin_in, exp_o.double_wash,
               exp_o.coin_reject, exp_o.change_valid, exp_o.change_amount, exp_o.credit, exp_o.busy);
    end
  endtask

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_type = 2'd0; double_req = 1'b0;
    start = 1'b0; cancel = 1'b0; wash_done = 1'b0;

    // Reset state
    tbl.push_back(mk(inp(1, 0, 2'd0, 0, 0, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    tbl.push_back(mk(inp(1, 0, 2'd0, 0, 0, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    // Invalid coin in IDLE is rejected; start and cancel in IDLE are ignored
    tbl.push_back(mk(coin(2'd3),                   outp(0, 0, 1, 0, 8'd0, 8'd0, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 1, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 0, 1, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    // 4x25c single wash, exact price: no change
    tbl.push_back(mk(coin(2'd0),                   outp(0, 0, 0, 0, 8'd0, 8'd25, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd25, 0)));
    tbl.push_back(mk(coin(2'd0),                   outp(0, 0, 0, 0, 8'd0, 8'd50, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd50, 0)));
    tbl.push_back(mk(coin(2'd0),                   outp(0, 0, 0, 0, 8'd0, 8'd75, 0)));
    tbl.push_back(mk(coin(2'd0),                   outp(0, 0, 0, 0, 8'd0, 8'd100, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 1, 0, 0), outp(1, 0, 0, 0, 8'd0, 8'd100, 1)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 1)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 1)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 0, 0, 1), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    // 100c+100c double wash: change 50, double_wash held until wash_done
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd100, 0)));
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd200, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 1, 1, 0, 0), outp(1, 1, 0, 1, 8'd50, 8'd200, 1)));
    tbl.push_back(mk(nop(),                        outp(0, 1, 0, 0, 8'd0, 8'd0, 1)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 1, 1, 0), outp(0, 1, 0, 0, 8'd0, 8'd0, 1)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 0, 0, 1), outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    // 100c, start for double with too little credit is ignored, then cancel
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd100, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 1, 1, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd100, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 0, 1, 0), outp(0, 0, 0, 1, 8'd100, 8'd100, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));
    // Ceiling: 200 + 100 rejected, invalid rejected, 200 + 50 = 250 accepted, +25 rejected
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd100, 0)));
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd200, 0)));
    tbl.push_back(mk(coin(2'd2),                   outp(0, 0, 1, 0, 8'd0, 8'd200, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd200, 0)));
    tbl.push_back(mk(coin(2'd3),                   outp(0, 0, 1, 0, 8'd0, 8'd200, 0)));
    tbl.push_back(mk(coin(2'd1),                   outp(0, 0, 0, 0, 8'd0, 8'd250, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd250, 0)));
    tbl.push_back(mk(coin(2'd0),                   outp(0, 0, 1, 0, 8'd0, 8'd250, 0)));
    tbl.push_back(mk(inp(0, 0, 2'd0, 0, 0, 1, 0), outp(0, 0, 0, 1, 8'd250, 8'd250, 0)));
    tbl.push_back(mk(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0)));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i, tbl[k].o, "table", k);
    end

    // cancel + coin together: coin rejected and full refund of prior credit
    apply(coin(2'd1),                   outp(0, 0, 0, 0, 8'd0, 8'd50, 0),  "cancel_coin", 0);
    apply(inp(0, 1, 2'd2, 0, 0, 1, 0), outp(0, 0, 1, 1, 8'd50, 8'd50, 0), "cancel_coin", 1);
    apply(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "cancel_coin", 2);

    // coin + start together: coin wins, start ignored; then exact double price
    apply(coin(2'd2),                   outp(0, 0, 0, 0, 8'd0, 8'd100, 0), "coin_start", 0);
    apply(inp(0, 1, 2'd1, 0, 1, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd150, 0), "coin_start", 1);
    apply(inp(0, 0, 2'd0, 1, 1, 0, 0), outp(1, 1, 0, 0, 8'd0, 8'd150, 1), "coin_start", 2);
    // Coin during RUN rejected, then reset mid-run clears everything
    apply(nop(),                        outp(0, 1, 0, 0, 8'd0, 8'd0, 1),   "run_reset", 0);
    apply(coin(2'd0),                   outp(0, 1, 1, 0, 8'd0, 8'd0, 1),   "run_reset", 1);
    apply(nop(),                        outp(0, 1, 0, 0, 8'd0, 8'd0, 1),   "run_reset", 2);
    apply(inp(1, 0, 2'd0, 0, 0, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "run_reset", 3);
    apply(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "run_reset", 4);

    // Reset in COLLECT forfeits credit without a refund pulse
    apply(coin(2'd1),                   outp(0, 0, 0, 0, 8'd0, 8'd50, 0),  "collect_reset", 0);
    apply(inp(1, 0, 2'd0, 0, 0, 0, 0), outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "collect_reset", 1);
    apply(nop(),                        outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "collect_reset", 2);

    // Inactivity: refund after exactly TIMEOUT idle cycles following the coin
    apply(coin(2'd1), outp(0, 0, 0, 0, 8'd0, 8'd50, 0), "timeout", 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      apply(nop(), outp(0, 0, 0, 0, 8'd0, 8'd50, 0), "timeout_wait", k);
    end
    apply(nop(), outp(0, 0, 0, 1, 8'd50, 8'd50, 0), "timeout", 1);
    apply(nop(), outp(0, 0, 0, 0, 8'd0, 8'd0, 0),   "timeout", 2);
    // Back in IDLE: a new coin is accepted normally
    apply(coin(2'd0), outp(0, 0, 0, 0, 8'd0, 8'd25, 0), "timeout", 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
